// File: rtl/sm83_pkg.sv
// Shared types and address map for the SM83 test-memory path.
package sm83_pkg;

    typedef logic [15:0] addr_t;
    typedef logic [7:0]  data_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        XFER  = 2'd2
    } dma_state_t;

    localparam addr_t DMA_REG_ADDR = 16'hFF46;
    localparam addr_t OAM_BASE     = 16'hFE00;
    localparam addr_t HRAM_BASE    = 16'hFF80;

endpackage

// File: rtl/oam_dma_seq.sv
// OAM DMA sequencer: start delay, per-byte phase counter and byte index.
// xfer/active are registered so they line up with the current phase/idx state.
module oam_dma_seq
    import sm83_pkg::*;
#(
    parameter int CYCLES_PER_BYTE = 4,
    parameter int DMA_LEN         = 160
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  start,
    input  data_t start_src,
    output logic  xfer,
    output addr_t idx,
    output data_t src_hi,
    output logic  active
);

    localparam int PH_W = $clog2(CYCLES_PER_BYTE);
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(CYCLES_PER_BYTE - 1);
    localparam addr_t IDX_LAST = addr_t'(DMA_LEN - 1);

    dma_state_t      state_q, state_d;
    logic [PH_W-1:0] phase_q, phase_d;
    addr_t           idx_q, idx_d;
    data_t           src_hi_q, src_hi_d;
    logic            xfer_q, xfer_d;
    logic            active_q, active_d;

    always_comb begin
        state_d  = state_q;
        phase_d  = phase_q;
        idx_d    = idx_q;
        src_hi_d = src_hi_q;
        case (state_q)
            IDLE: ;
            START: begin
                if (phase_q == PH_LAST) begin
                    state_d = XFER;
                    phase_d = '0;
                    idx_d   = '0;
                end else begin
                    phase_d = phase_q + PH_W'(1);
                end
            end
            XFER: begin
                if (phase_q == PH_LAST) begin
                    phase_d = '0;
                    if (idx_q == IDX_LAST) begin
                        state_d = IDLE;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + 16'd1;
                    end
                end else begin
                    phase_d = phase_q + PH_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        // A register write restarts from scratch, whatever the state.
        if (start) begin
            src_hi_d = start_src;
            state_d  = START;
            phase_d  = '0;
            idx_d    = '0;
        end
        xfer_d   = (state_d == XFER) && (phase_d == PH_LAST);
        active_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            phase_q  <= '0;
            idx_q    <= '0;
            src_hi_q <= 8'h00;
            xfer_q   <= 1'b0;
            active_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            idx_q    <= idx_d;
            src_hi_q <= src_hi_d;
            xfer_q   <= xfer_d;
            active_q <= active_d;
        end
    end

    assign xfer   = xfer_q;
    assign idx    = idx_q;
    assign src_hi = src_hi_q;
    assign active = active_q;

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares the test-memory port pair between the CPU bus and the OAM DMA copy.
// Optional macro DMA_BUS_CONFLICT_EN blocks CPU accesses below HRAM while DMA runs.
module mem_bus_arbiter
    import sm83_pkg::*;
#(
    parameter int CYCLES_PER_BYTE = 4,
    parameter int DMA_LEN         = 160
) (
    input  logic  clk,
    input  logic  rst,
    input  addr_t cpu_addr,
    input  logic  cpu_rd,
    input  logic  cpu_wr,
    input  data_t cpu_wdata,
    output data_t cpu_rdata,
    output logic  cpu_stall,
    output addr_t mem_r_addr,
    input  data_t mem_r_data,
    output addr_t mem_w_addr,
    output data_t mem_w_data,
    output logic  mem_wen,
    output logic  dma_active
);

    logic  xfer, active, dma_hit, rd_req, blocked, seq_start;
    addr_t idx;
    data_t src_hi;

    assign dma_hit = (cpu_addr == DMA_REG_ADDR);
    assign rd_req  = cpu_rd && !cpu_wr;

`ifdef DMA_BUS_CONFLICT_EN
    assign blocked = active && (cpu_addr < HRAM_BASE) && !dma_hit;
`else
    assign blocked = 1'b0;
`endif

    // A register write landing on a transfer cycle is stalled and retried.
    assign seq_start = cpu_wr && dma_hit && !xfer;

    oam_dma_seq #(
        .CYCLES_PER_BYTE(CYCLES_PER_BYTE),
        .DMA_LEN        (DMA_LEN)
    ) u_seq (
        .clk      (clk),
        .rst      (rst),
        .start    (seq_start),
        .start_src(cpu_wdata),
        .xfer     (xfer),
        .idx      (idx),
        .src_hi   (src_hi),
        .active   (active)
    );

    always_comb begin
        mem_r_addr = cpu_addr;
        mem_w_addr = cpu_addr;
        mem_w_data = cpu_wdata;
        mem_wen    = cpu_wr && !dma_hit && !blocked;
        cpu_stall  = 1'b0;
        if (dma_hit)
            cpu_rdata = src_hi;
        else if (blocked || !rd_req)
            cpu_rdata = 8'hFF;
        else
            cpu_rdata = mem_r_data;
        if (xfer) begin
            mem_r_addr = {src_hi, idx[7:0]};
            mem_w_addr = OAM_BASE + idx;
            mem_w_data = mem_r_data;
            mem_wen    = 1'b1;
            cpu_stall  = 1'b1;
        end
    end

    assign dma_active = active;

endmodule
